// File: rtl/i2s_rx_stereo_pkg.sv
// Shared types and constants for the stereo I2S receiver.
// Holds the FSM state encoding, channel ids and the bit-counter width helper.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } i2s_rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  // Bit counter saturates at 63, so it always needs 6 bits.
  localparam int CNT_MAX = 63;
  localparam int CNT_W   = cnt_width(CNT_MAX);

endpackage

// File: rtl/i2s_rx_stereo_if.sv
// Word output port of the I2S receiver: channel-tagged data behind valid/ready.
interface i2s_rx_stereo_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_data;
  logic              out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/i2s_rx_stereo_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop frees a slot for a same-cycle push when full.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S receiver: synchronises ws/sck, deserialises both half-frames and
// queues channel-tagged words, flagging bad slot lengths and FIFO overflow.
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter int         SLOT_W     = 32,
  parameter logic [1:0] CH_EN      = 2'b11,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ws,
  input  logic              sck,
  input  logic              sd,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              ovf,
  i2s_rx_stereo_if.master   rx
);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_CNT  = CNT_W'(SLOT_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  i2s_rx_state_t     state, state_nxt;
  logic              ws_s1, ws_s2, ws_s3;
  logic              sck_s1, sck_s2, sck_s3;
  logic              ws_edge, sck_rise;
  logic              run_act, run_entry, in_word;
  logic [CNT_W-1:0]  cnt;
  logic              cur_ch;
  logic [DATA_W-1:0] shift_reg;
  logic              vld_p1;
  logic              frame_set, ovf_set;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_head;

  // Stage p0: two-flop synchronisers plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {ws_s1, ws_s2, ws_s3}    <= '0;
      {sck_s1, sck_s2, sck_s3} <= '0;
    end else begin
      {ws_s1, ws_s2, ws_s3}    <= {ws, ws_s1, ws_s2};
      {sck_s1, sck_s2, sck_s3} <= {sck, sck_s1, sck_s2};
    end
  end

  assign ws_edge   = ws_s2 ^ ws_s3;
  assign sck_rise  = sck_s2 & ~sck_s3;
  assign run_act   = (state == RUN) && en;
  assign run_entry = (state == ALIGN) && en && ws_edge;
  assign in_word   = (cnt != '0) && (cnt <= DATA_LAST);
  assign frame_set = run_act && ws_edge && (cnt != SLOT_CNT);
  assign fifo_pop  = rx.out_valid & rx.out_ready;
  assign ovf_set   = vld_p1 & fifo_full & ~fifo_pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = ALIGN;
      ALIGN:   if (!en) state_nxt = IDLE;
               else if (ws_edge) state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: slot counter, word-complete strobe and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cur_ch    <= 1'b0;
      vld_p1    <= 1'b0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (run_entry || (run_act && ws_edge)) begin
        cnt    <= '0;
        cur_ch <= ws_s2;
      end else if (run_act && sck_rise) begin
        cnt <= sat_inc(cnt);
        if (cnt == DATA_LAST && CH_EN[cur_ch]) vld_p1 <= 1'b1;
      end else if (!run_act) begin
        cnt <= '0;
      end

      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;

      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
    end
  end

  // The cnt==0 rise is the I2S one-bit delay slot and never lands in the word.
  always_ff @(posedge clk) begin
    if (run_act && sck_rise && !ws_edge && in_word)
      shift_reg <= {shift_reg[DATA_W-2:0], sd};
  end

  // Stage p2: channel-tagged word enters the output FIFO
  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data ({cur_ch, shift_reg}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign rx.out_valid = ~fifo_empty;
  assign rx.out_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign rx.out_ch    = fifo_empty ? CH_LEFT : fifo_head[DATA_W];
endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Scoreboard bench for i2s_rx_stereo: three instances (stereo, right-only, 24-bit) fed by one I2S source.
module tb_i2s_rx_stereo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ws = 1'b1, sck = 1'b0, sd = 1'b0, err_clr = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic ferr_a, ferr_b, ferr_c, ovf_a, ovf_b, ovf_c;

  int tests = 0;
  int fails = 0;
  logic [32:0] q_a[$], q_b[$], q_c[$];
  logic [32:0] e_a, e_b, e_c;

  always #5 clk = ~clk;

  i2s_rx_stereo_if #(.DATA_W(16)) bus_a();
  i2s_rx_stereo_if #(.DATA_W(16)) bus_b();
  i2s_rx_stereo_if #(.DATA_W(24)) bus_c();
  assign bus_a.out_ready = ready_a;
  assign bus_b.out_ready = ready_b;
  assign bus_c.out_ready = ready_c;

  i2s_rx_stereo #(.DATA_W(16), .SLOT_W(32), .CH_EN(2'b11), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .ws(ws), .sck(sck), .sd(sd), .err_clr(err_clr),
    .frame_err(ferr_a), .ovf(ovf_a), .rx(bus_a));
  i2s_rx_stereo #(.DATA_W(16), .SLOT_W(32), .CH_EN(2'b10), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .ws(ws), .sck(sck), .sd(sd), .err_clr(err_clr),
    .frame_err(ferr_b), .ovf(ovf_b), .rx(bus_b));
  i2s_rx_stereo #(.DATA_W(24), .SLOT_W(32), .CH_EN(2'b11), .FIFO_DEPTH(4)) i2s_rx_stereo (
    .clk(clk), .rst(rst), .en(en_c), .ws(ws), .sck(sck), .sd(sd), .err_clr(err_clr),
    .frame_err(ferr_c), .ovf(ovf_c), .rx(bus_c));

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitors: pop the expected word whenever a handshake will occur on the next rising edge.
  always @(negedge clk) begin
    if (bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected: got ch=%0d data=%h, required no word", bus_a.out_ch, bus_a.out_data);
      end else begin
        e_a = q_a.pop_front();
        cmp("a_word", {31'd0, bus_a.out_ch, 32'(bus_a.out_data)}, {31'd0, e_a});
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: got ch=%0d data=%h, required no word", bus_b.out_ch, bus_b.out_data);
      end else begin
        e_b = q_b.pop_front();
        cmp("b_word", {31'd0, bus_b.out_ch, 32'(bus_b.out_data)}, {31'd0, e_b});
      end
    end
  end

  always @(negedge clk) begin
    if (bus_c.out_valid === 1'b1 && bus_c.out_ready === 1'b1) begin
      if (q_c.size() == 0) begin
        tests++; fails++;
        $display("FAIL c_unexpected: got ch=%0d data=%h, required no word", bus_c.out_ch, bus_c.out_data);
      end else begin
        e_c = q_c.pop_front();
        cmp("c_word", {31'd0, bus_c.out_ch, 32'(bus_c.out_data)}, {31'd0, e_c});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One WS half-frame: sck = clk/32, ws and sd change on sck falling edges.
  // evt 1 drops en_a after rise evt_at; evt 2 stops the slot after rise evt_at.
  task automatic slot(input logic wsv, input logic [31:0] word, input int dw,
                      input int rises, input int evt_at, input int evt);
    ws = wsv;
    sd = 1'b0;
    for (int k = 1; k <= rises; k++) begin
      tick(16);
      sck = 1'b1;
      tick(16);
      sck = 1'b0;
      sd = (k <= dw) ? word[dw-k] : 1'b0;
      if (k == evt_at && evt == 1) en_a = 1'b0;
      if (k == evt_at && evt == 2) break;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(5);
    cmp("rst_a_valid", 64'(bus_a.out_valid), 64'd0);
    cmp("rst_a_data",  64'(bus_a.out_data),  64'd0);
    cmp("rst_a_ch",    64'(bus_a.out_ch),    64'd0);
    cmp("rst_a_ferr",  64'(ferr_a),          64'd0);
    cmp("rst_a_ovf",   64'(ovf_a),           64'd0);
    cmp("rst_c_valid", 64'(bus_c.out_valid), 64'd0);
    rst = 1'b0;
    tick(5);

    // Stereo stream into A and right-only B; alignment happens on the first ws edge.
    en_a = 1'b1; en_b = 1'b1;
    tick(5);
    for (int i = 0; i < 2; i++) begin
      q_a.push_back({1'b0, 32'h0000A5C3});
      slot(1'b0, 32'h0000A5C3, 16, 32, 0, 0);
      q_a.push_back({1'b1, 32'h00001234});
      q_b.push_back({1'b1, 32'h00001234});
      slot(1'b1, 32'h00001234, 16, 32, 0, 0);
    end
    tick(10);
    cmp("t1_a_ferr", 64'(ferr_a), 64'd0);
    cmp("t1_a_ovf",  64'(ovf_a),  64'd0);
    cmp("t2_b_ferr", 64'(ferr_b), 64'd0);
    cmp("t2_b_ovf",  64'(ovf_b),  64'd0);
    en_b = 1'b0;

    // Six words against a stalled 4-deep FIFO: the last two are dropped.
    ready_a = 1'b0;
    q_a.push_back({1'b0, 32'h00001111});
    slot(1'b0, 32'h00001111, 16, 32, 0, 0);
    q_a.push_back({1'b1, 32'h00002222});
    slot(1'b1, 32'h00002222, 16, 32, 0, 0);
    q_a.push_back({1'b0, 32'h00003333});
    slot(1'b0, 32'h00003333, 16, 32, 0, 0);
    q_a.push_back({1'b1, 32'h00004444});
    slot(1'b1, 32'h00004444, 16, 32, 0, 0);
    slot(1'b0, 32'h00005555, 16, 32, 0, 0);
    slot(1'b1, 32'h00006666, 16, 32, 0, 0);
    cmp("t3_held_valid", 64'(bus_a.out_valid), 64'd1);
    cmp("t3_head_data",  64'(bus_a.out_data),  64'h1111);
    cmp("t3_ovf",        64'(ovf_a),           64'd1);
    cmp("t3_ferr",       64'(ferr_a),          64'd0);
    ready_a = 1'b1;
    tick(20);
    cmp("t3_drained_valid", 64'(bus_a.out_valid), 64'd0);
    cmp("t3_drained_count", 64'(q_a.size()),      64'd0);
    pulse_clr();
    cmp("t3_ovf_clr", 64'(ovf_a), 64'd0);

    // Long-ish slot (20 rises) still yields a word; a 10-rise slot yields none.
    q_a.push_back({1'b0, 32'h0000BEEF});
    slot(1'b0, 32'h0000BEEF, 16, 20, 0, 0);
    slot(1'b1, 32'h0000CAFE, 16, 10, 0, 0);
    q_a.push_back({1'b0, 32'h00000F0F});
    slot(1'b0, 32'h00000F0F, 16, 32, 0, 0);
    cmp("t4_ferr", 64'(ferr_a), 64'd1);
    cmp("t4_ovf",  64'(ovf_a),  64'd0);
    pulse_clr();
    cmp("t4_ferr_clr", 64'(ferr_a), 64'd0);
    q_a.push_back({1'b1, 32'h00001357});
    slot(1'b1, 32'h00001357, 16, 32, 0, 0);
    cmp("t4_ferr_clean", 64'(ferr_a), 64'd0);

    // en dropped after the 8th captured bit, re-enabled three slots later.
    slot(1'b0, 32'h0000DEAD, 16, 32, 9, 1);
    slot(1'b1, 32'h0000FFFF, 16, 32, 0, 0);
    slot(1'b0, 32'h0000FFFF, 16, 32, 0, 0);
    slot(1'b1, 32'h0000FFFF, 16, 32, 0, 0);
    cmp("t5_idle_valid", 64'(bus_a.out_valid), 64'd0);
    en_a = 1'b1;
    tick(4);
    q_a.push_back({1'b0, 32'h00005A5A});
    slot(1'b0, 32'h00005A5A, 16, 32, 0, 0);
    q_a.push_back({1'b1, 32'h0000A5A5});
    slot(1'b1, 32'h0000A5A5, 16, 32, 0, 0);
    tick(10);
    cmp("t5_ferr", 64'(ferr_a), 64'd0);
    en_a = 1'b0;

    // 24-bit instance: extreme patterns, then a reset in the middle of a word.
    en_c = 1'b1;
    tick(4);
    q_c.push_back({1'b0, 32'h00800001});
    slot(1'b0, 32'h00800001, 24, 32, 0, 0);
    q_c.push_back({1'b1, 32'h007FFFFE});
    slot(1'b1, 32'h007FFFFE, 24, 32, 0, 0);
    tick(20);
    cmp("t6_c_ferr", 64'(ferr_c), 64'd0);
    ready_c = 1'b0;
    slot(1'b0, 32'h00ABCDEF, 24, 26, 0, 0);
    slot(1'b1, 32'h00123456, 24, 32, 10, 2);
    cmp("t6_pre_valid", 64'(bus_c.out_valid), 64'd1);
    cmp("t6_pre_head",  {31'd0, bus_c.out_ch, 32'(bus_c.out_data)}, 64'h00ABCDEF);
    cmp("t6_pre_ferr",  64'(ferr_c), 64'd1);
    rst = 1'b1;
    tick(1);
    cmp("t6_rst_valid", 64'(bus_c.out_valid), 64'd0);
    cmp("t6_rst_data",  64'(bus_c.out_data),  64'd0);
    cmp("t6_rst_ch",    64'(bus_c.out_ch),    64'd0);
    cmp("t6_rst_ferr",  64'(ferr_c),          64'd0);
    cmp("t6_rst_ovf",   64'(ovf_c),           64'd0);
    rst = 1'b0;
    ready_c = 1'b1;
    tick(20);

    cmp("end_q_a", 64'(q_a.size()), 64'd0);
    cmp("end_q_b", 64'(q_b.size()), 64'd0);
    cmp("end_q_c", 64'(q_c.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
